// File: rtl/cbd_stream_sampler.sv
// Centered-binomial sampler: turns 64-bit PRF lanes into 128 beats of two mod-q coefficients.
// Define CBD_CENTERED_OUT_EN to emit signed 12-bit two's-complement coefficients instead of q-mapped ones.
module cbd_stream_sampler #(
    parameter int Q      = 3329,
    parameter int N_COEF = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        eta3_i,
    output logic        busy_o,
    output logic        done_o,
    input  logic [63:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [23:0] coef_o,
    output logic        coef_valid_o,
    input  logic        coef_ready_i,
    output logic [7:0]  coef_idx_o
);

    localparam int BEATS = N_COEF / 2;
    localparam int W2    = N_COEF * 2 / 32;
    localparam int W3    = N_COEF * 3 / 32;
    localparam int WW    = $clog2(W3 + 1);
    localparam logic [11:0] Q12 = 12'(Q);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic            eta3;
    logic [127:0]    bits;
    logic [7:0]      cnt;
    logic [WW-1:0]   words;
    logic [7:0]      idx;

    logic [7:0]      bits_per_beat;
    logic [WW-1:0]   word_limit;
    logic            take;
    logic            accept;
    logic            last_beat;
    logic [127:0]    shifted;
    logic [7:0]      cnt_shift;
    logic [127:0]    bits_next;
    logic [7:0]      cnt_next;

    function automatic logic [11:0] cbd_coef(input logic [2:0] a_bits, input logic [2:0] b_bits);
        logic [1:0] a;
        logic [1:0] b;
        a = 2'(a_bits[0]) + 2'(a_bits[1]) + 2'(a_bits[2]);
        b = 2'(b_bits[0]) + 2'(b_bits[1]) + 2'(b_bits[2]);
        if (a >= b)
            return {10'd0, a - b};
`ifdef CBD_CENTERED_OUT_EN
        return 12'd0 - {10'd0, b - a};
`else
        return Q12 - {10'd0, b - a};
`endif
    endfunction

    assign bits_per_beat = eta3 ? 8'd12 : 8'd8;
    assign word_limit    = eta3 ? WW'(W3) : WW'(W2);
    assign in_ready_o    = (state == RUN) && (cnt <= 8'd64) && (words < word_limit);
    assign coef_valid_o  = (state == RUN) && (cnt >= bits_per_beat);
    assign take          = coef_valid_o && coef_ready_i;
    assign accept        = in_valid_i && in_ready_o;
    assign last_beat     = take && (idx == 8'(BEATS - 1));
    assign coef_idx_o    = idx;

    // Consumption shift happens first so an accepted lane lands right after the surviving bits.
    always_comb begin
        shifted   = bits;
        cnt_shift = cnt;
        if (take) begin
            shifted   = eta3 ? (bits >> 12) : (bits >> 8);
            cnt_shift = cnt - bits_per_beat;
        end
        bits_next = shifted;
        cnt_next  = cnt_shift;
        if (accept) begin
            bits_next = shifted | ({64'd0, in_data_i} << cnt_shift);
            cnt_next  = cnt_shift + 8'd64;
        end
    end

    always_comb begin
        if (eta3)
            coef_o = {cbd_coef(bits[8:6], bits[11:9]), cbd_coef(bits[2:0], bits[5:3])};
        else
            coef_o = {cbd_coef({1'b0, bits[5:4]}, {1'b0, bits[7:6]}),
                      cbd_coef({1'b0, bits[1:0]}, {1'b0, bits[3:2]})};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state)
            IDLE: if (start_i) state_next = RUN;
            RUN: begin
                busy_o = 1'b1;
                if (last_beat) state_next = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            eta3  <= 1'b0;
            bits  <= '0;
            cnt   <= '0;
            words <= '0;
            idx   <= '0;
        end else if (state == IDLE && start_i) begin
            eta3  <= eta3_i;
            bits  <= '0;
            cnt   <= '0;
            words <= '0;
            idx   <= '0;
        end else if (state == RUN) begin
            bits <= bits_next;
            cnt  <= cnt_next;
            if (accept)
                words <= words + WW'(1);
            if (last_beat)
                idx <= '0;
            else if (take)
                idx <= idx + 8'd1;
        end
    end

endmodule

// File: tb/tb_cbd_stream_sampler.sv
// Scoreboard bench for cbd_stream_sampler: directed lane streams, expected beats queued at issue time.
module tb_cbd_stream_sampler;

    localparam int Q = 3329;

    logic        clk;
    logic        rst_i;
    logic        start_i;
    logic        eta3_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] in_data_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [23:0] coef_o;
    logic        coef_valid_o;
    logic        coef_ready_i;
    logic [7:0]  coef_idx_o;

    cbd_stream_sampler #(.Q(3329), .N_COEF(256)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .eta3_i       (eta3_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .in_data_i    (in_data_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .coef_o       (coef_o),
        .coef_valid_o (coef_valid_o),
        .coef_ready_i (coef_ready_i),
        .coef_idx_o   (coef_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] coef;
        logic [7:0]  idx;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] lane_q[$];
    logic [63:0] pat[25];
    int checks = 0;
    int failures = 0;
    int lanes_taken = 0;
    int done_cnt = 0;
    int beats_seen = 0;
    int stall = 0;
    bit saw_ready_drop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Lane source and sink-ready driver: handshakes sampled at negedge, inputs updated #1 after posedge.
    initial begin : driver
        bit lane_fire;
        forever begin
            @(negedge clk);
            lane_fire = in_valid_i && in_ready_o;
            if (busy_o && !in_ready_o && !coef_ready_i && lane_q.size() > 0)
                saw_ready_drop = 1;
            @(posedge clk);
            #1;
            if (lane_fire && lane_q.size() > 0) begin
                void'(lane_q.pop_front());
                lanes_taken++;
            end
            in_valid_i   = (lane_q.size() > 0);
            in_data_i    = (lane_q.size() > 0) ? lane_q[0] : 64'd0;
            coef_ready_i = (stall == 0);
            if (stall > 0) stall--;
        end
    end

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            if (done_o) done_cnt++;
            if (coef_valid_o && coef_ready_i) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual_idx=%0d required=no_beat", coef_idx_o);
                end else begin
                    e = exp_q.pop_front();
                    check("coef", {8'd0, coef_o}, {8'd0, e.coef});
                    check("coef_idx", {24'd0, coef_idx_o}, {24'd0, e.idx});
                end
            end
        end
    end

    function automatic logic [11:0] model_coef(input int e, input int j);
        int a;
        int b;
        int v;
        int n;
        logic [63:0] lane;
        a = 0;
        b = 0;
        for (int i = 0; i < 2 * e; i++) begin
            n = j * 2 * e + i;
            lane = pat[n / 64];
            if (i < e) a += int'(lane[n % 64]);
            else       b += int'(lane[n % 64]);
        end
        v = a - b;
`ifdef CBD_CENTERED_OUT_EN
        return 12'(v);
`else
        return (v < 0) ? 12'(Q + v) : 12'(v);
`endif
    endfunction

    task automatic push_model(input int e, input int nwords);
        for (int i = 0; i <= nwords; i++) lane_q.push_back(pat[i]);
        for (int k = 0; k < 128; k++)
            exp_q.push_back('{coef: {model_coef(e, 2 * k + 1), model_coef(e, 2 * k)}, idx: 8'(k)});
    endtask

    task automatic push_const(input logic [63:0] first, input logic [63:0] rest, input int nwords,
                              input logic [23:0] beat0);
        lane_q.push_back(first);
        for (int i = 1; i <= nwords; i++) lane_q.push_back(rest);
        exp_q.push_back('{coef: beat0, idx: 8'd0});
        for (int k = 1; k < 128; k++) exp_q.push_back('{coef: 24'd0, idx: 8'(k)});
    endtask

    task automatic start_poly(input bit e3, input int stall_cycles);
        lanes_taken = 0;
        @(posedge clk);
        #2;
        start_i      = 1'b1;
        eta3_i       = e3;
        stall        = stall_cycles;
        coef_ready_i = (stall_cycles == 0);
        @(posedge clk);
        #2;
        start_i = 1'b0;
        eta3_i  = ~e3;
        @(negedge clk);
        check("busy_after_start", {31'd0, busy_o}, 32'd1);
        check("in_ready_after_start", {31'd0, in_ready_o}, 32'd1);
    endtask

    task automatic run_poly(input bit e3, input int nwords, input int stall_cycles);
        int d0;
        d0 = done_cnt;
        start_poly(e3, stall_cycles);
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("done_pulses", done_cnt - d0, 32'd1);
        check("lanes_taken", lanes_taken, nwords);
        check("beats_left", exp_q.size(), 32'd0);
        check("busy_after_done", {31'd0, busy_o}, 32'd0);
        lane_q.delete();
        exp_q.delete();
    endtask

    initial begin : main
        int b0;
        rst_i        = 1'b1;
        start_i      = 1'b0;
        eta3_i       = 1'b0;
        in_valid_i   = 1'b0;
        in_data_i    = 64'd0;
        coef_ready_i = 1'b1;
        for (int i = 0; i < 25; i++)
            pat[i] = 64'h9E37_79B9_7F4A_7C15 ^ (64'(i) * 64'h0101_0101_0101_0101) ^ (64'(i) << 37);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        check("rst_coef_valid", {31'd0, coef_valid_o}, 32'd0);
        check("rst_coef", {8'd0, coef_o}, 32'd0);
        check("rst_coef_idx", {24'd0, coef_idx_o}, 32'd0);
        @(posedge clk);
        #3;
        rst_i = 1'b0;

        // eta2 all-zero lanes
        push_const(64'd0, 64'd0, 16, 24'd0);
        run_poly(1'b0, 16, 0);

        // eta2 lane 0xC3: coef0 = 2, coef1 = -2
`ifdef CBD_CENTERED_OUT_EN
        push_const(64'h0000_0000_0000_00C3, 64'd0, 16, {12'hFFE, 12'd2});
`else
        push_const(64'h0000_0000_0000_00C3, 64'd0, 16, {12'd3327, 12'd2});
`endif
        run_poly(1'b0, 16, 0);

        // eta3 lane 0x0E07: coef0 = 3, coef1 = -3
`ifdef CBD_CENTERED_OUT_EN
        push_const(64'h0000_0000_0000_0E07, 64'd0, 24, {12'hFFD, 12'd3});
`else
        push_const(64'h0000_0000_0000_0E07, 64'd0, 24, {12'd3326, 12'd3});
`endif
        run_poly(1'b1, 24, 0);

        // eta2 all-ones with the sink stalled at start
        saw_ready_drop = 0;
        push_const('1, '1, 16, 24'd0);
        run_poly(1'b0, 16, 20);
        check("in_ready_dropped", {31'd0, saw_ready_drop}, 32'd1);

        // eta2 patterned run reset after beat 40, then a fresh eta3 run
        push_model(2, 16);
        b0 = beats_seen;
        start_poly(1'b0, 0);
        for (int i = 0; i < 500 && beats_seen - b0 <= 40; i++) @(negedge clk);
        check("beats_before_reset", {31'd0, (beats_seen - b0) > 40}, 32'd1);
        @(posedge clk);
        #3;
        rst_i = 1'b1;
        lane_q.delete();
        exp_q.delete();
        @(negedge clk);
        check("midrun_rst_busy", {31'd0, busy_o}, 32'd0);
        check("midrun_rst_idx", {24'd0, coef_idx_o}, 32'd0);
        check("midrun_rst_valid", {31'd0, coef_valid_o}, 32'd0);
        @(posedge clk);
        #3;
        rst_i = 1'b0;
        push_model(3, 24);
        run_poly(1'b1, 24, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cbd_stream_sampler.md
# cbd_stream_sampler

Streaming centered-binomial sampler for the Kyber polynomial path. It sits directly downstream of the SHAKE256 PRF squeeze port and consumes 64-bit output lanes under a valid/ready handshake. Each lane is converted into coefficients of one 256-coefficient polynomial with eta = 2 or 3. Coefficients are emitted two per beat, reduced mod q, to the polynomial buffer and NTT stage.

## Interface
- Q, 3329, modulus used for negative-value mapping
- N_COEF, 256, coefficients per polynomial (must be even)

- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse that begins one polynomial; ignored unless IDLE
- eta3_i  in  1  0: eta=2, 1: eta=3; sampled only when start_i is accepted
- busy_o  out  1  high from the cycle after start until done_o
- done_o  out  1  one-cycle pulse after the last beat is taken
- in_data_i  in  64  PRF lane; bit 0 is stream bit 0 (byte 0 LSB)
- in_valid_i  in  1  lane valid
- in_ready_o  out  1  lane accepted when in_valid_i & in_ready_o
- coef_o  out  24  [11:0] coefficient 2k, [23:12] coefficient 2k+1
- coef_valid_o  out  1  beat valid
- coef_ready_i  in  1  beat taken when coef_valid_o & coef_ready_i
- coef_idx_o  out  8  k (beat index, 0..127)

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on start_i; latch eta, clear bit count, word count and beat index.
  - RUN→DONE when beat 127 is taken.
  - DONE→IDLE unconditionally after 1 cycle; done_o=1 only in DONE.
- Bit buffer: 128-bit register holding unconsumed bits LSB-first, plus count cnt (0..128).
- in_ready_o = RUN & cnt ≤ 64 & words_in < W, where W = 16 (eta2) or 24 (eta3). An accepted word is appended at bit position cnt (after any same-cycle consumption shift).
- Bits per beat B = 4·eta (8 or 12). coef_valid_o = RUN & cnt ≥ B. A taken beat shifts the buffer right by B and decrements cnt by B.
- Accept and consume in the same cycle are both applied: cnt' = cnt − B + 64.
- Coefficient from 2·eta consecutive bits: a = popcount(first eta bits), b = popcount(next eta bits), v = a − b ∈ [−eta, eta]. Output v if v ≥ 0, else Q + v (12 bits). The lower-indexed coefficient goes in [11:0].
- Total input is exactly 1024 bits (eta2) or 1536 bits (eta3). Input is never over-requested, and the buffer is empty at DONE.
- start_i during RUN/DONE is ignored. eta3_i changes during RUN have no effect.
- rst_i at any time: state IDLE, cnt=0, all counters 0, buffer contents don't-care. The upstream PRF must be restarted by its owner.

## Timing
- Reset values:
  - busy_o=0, done_o=0, in_ready_o=0, coef_valid_o=0, coef_o=0, coef_idx_o=0.
  - coef_o/coef_idx_o are driven combinationally from the buffer and index and read 0 when the buffer is cleared.
- start_i at edge t → busy_o and in_ready_o high from t+1.
- First lane accepted at edge t1 → coef_valid_o high in cycle t1+1 (1-cycle latency). coef_o is combinational from registered state.
- With in_valid_i and coef_ready_i held high: eta2 sustains 1 beat/cycle; eta3 sustains 1 beat/cycle. The buffer never starves after the first lane because 64 ≥ 5.33·B/… refill once every ≤ 8 beats.
- Full polynomial, no backpressure: 128 beats + 1 fill cycle. done_o asserts the cycle after the last beat edge.

## Configuration
- CBD_CENTERED_OUT_EN:
  - Defined: coef_o fields carry v as 12-bit two's complement (e.g. −2 → 12'hFFE) with no Q mapping, for a signed downstream datapath.
  - Undefined: Q + v mapping as above (−2 → 3327). The port width is unchanged in both cases.

## Test plan
- eta2, 16 lanes of all zeros, coef_ready_i=1 → 128 beats of coef_o=0, coef_idx_o 0..127 in order, done_o one pulse, exactly 16 lanes accepted.
- eta2, first lane 64'h0000_0000_0000_00C3, rest zero → beat 0 coef_o[11:0]=2, [23:12]=3327. All other coefficients are 0.
- eta3, first lane 64'h0000_0000_0000_0E07, rest zero, 24 lanes → coef0=3, coef1=3326 (bits 9..11 set: b=3). Exactly 24 lanes accepted.
- eta2 all-ones lanes with coef_ready_i low for 20 cycles → in_ready_o drops once cnt>64, no lane lost. All coefficients are 0, and done_o still occurs after 128 beats.
- Reset mid-run after beat 40, then a new start with eta3 → outputs match the fresh eta3 reference, and the beat index restarts at 0.
- With CBD_CENTERED_OUT_EN, repeat the second scenario → coef_o[23:12]=12'hFFE.
